// File: rtl/row_serializer.sv
// Row-to-stream serializer: buffers one WIDTH x CHANNELS row and emits it one value per
// cycle (channel inner, column outer), flagging row end, frame end and counting frames.
module row_serializer #(
  parameter int VALUE_BITS     = 8,
  parameter int WIDTH          = 28,
  parameter int CHANNELS       = 2,
  parameter int FRAME_CNT_BITS = 16
) (
  input  logic                                             clock_i,
  input  logic                                             reset_i,
  input  logic [WIDTH-1:0][CHANNELS-1:0][VALUE_BITS-1:0]   in_row_i,
  input  logic                                             in_row_valid_i,
  output logic                                             in_row_accept_o,
  input  logic                                             in_row_last_i,
  output logic [VALUE_BITS-1:0]                            out_value_o,
  output logic                                             out_valid_o,
  input  logic                                             out_ready_i,
  output logic                                             out_row_end_o,
  output logic                                             out_last_o,
  output logic [FRAME_CNT_BITS-1:0]                        frames_done_o
);

  localparam int COL_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(WIDTH - 1);
  localparam logic [CH_BITS-1:0]  CH_MAX  = CH_BITS'(CHANNELS - 1);

  logic [WIDTH-1:0][CHANNELS-1:0][VALUE_BITS-1:0] row_buf;
  logic                full;
  logic                last_q;
  logic [COL_BITS-1:0] col;
  logic [CH_BITS-1:0]  ch;

  logic at_end;
  logic beat;
  logic final_beat;
  logic load;

  // Handshakes: a row moves on a posedge with in_row_valid_i && in_row_accept_o; a value
  // moves on a posedge with out_valid_o && out_ready_i. Neither valid depends on its ready.
  assign at_end     = (col == COL_MAX) && (ch == CH_MAX);
  assign beat       = full && out_ready_i;
  assign final_beat = beat && at_end;
  assign load       = in_row_valid_i && in_row_accept_o;

  // Accepting during the final beat lets the next row follow with no idle cycle.
  assign in_row_accept_o = !reset_i && (!full || final_beat);

  assign out_valid_o   = full;
  assign out_value_o   = row_buf[col][ch];
  assign out_row_end_o = full && at_end;
  assign out_last_o    = out_row_end_o && last_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      full          <= 1'b0;
      last_q        <= 1'b0;
      col           <= '0;
      ch            <= '0;
      frames_done_o <= '0;
    end else begin
      if (beat && out_last_o) begin
        frames_done_o <= frames_done_o + FRAME_CNT_BITS'(1);
      end
      if (load) begin
        row_buf <= in_row_i;
        last_q  <= in_row_last_i;
        full    <= 1'b1;
        col     <= '0;
        ch      <= '0;
      end else if (final_beat) begin
        full <= 1'b0;
        col  <= '0;
        ch   <= '0;
      end else if (beat) begin
        if (ch == CH_MAX) begin
          ch  <= '0;
          col <= col + COL_BITS'(1);
        end else begin
          ch <= ch + CH_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_row_serializer.sv
// Bench for row_serializer: every accepted row is expanded into its expected beat list,
// and each cycle the DUT's handshake, value and flags are compared against that list.
module tb_row_serializer;

  localparam int VB = 8;
  localparam int W  = 28;
  localparam int C  = 2;
  localparam int FB = 16;
  localparam int RB = W * C;

  logic                       clock_i = 1'b0;
  logic                       reset_i;
  logic [W-1:0][C-1:0][VB-1:0] in_row_i;
  logic                       in_row_valid_i;
  logic                       in_row_accept_o;
  logic                       in_row_last_i;
  logic [VB-1:0]              out_value_o;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic                       out_row_end_o;
  logic                       out_last_o;
  logic [FB-1:0]              frames_done_o;

  always #5 clock_i = ~clock_i;

  row_serializer #(
    .VALUE_BITS(VB), .WIDTH(W), .CHANNELS(C), .FRAME_CNT_BITS(FB)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .in_row_i       (in_row_i),
    .in_row_valid_i (in_row_valid_i),
    .in_row_accept_o(in_row_accept_o),
    .in_row_last_i  (in_row_last_i),
    .out_value_o    (out_value_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_row_end_o  (out_row_end_o),
    .out_last_o     (out_last_o),
    .frames_done_o  (frames_done_o)
  );

  // Reference model: {last, row_end, value} per pending beat, in output order.
  logic [VB+1:0] exp_q[$];
  int            rem = 0;
  logic [FB-1:0] frames_exp = '0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            beat_count = 0;
  int            cyc = 0;
  int            first_beat_cyc = -1;
  int            last_beat_cyc = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  task automatic push_row();
    logic [VB+1:0] e;
    logic          re;
    for (int w = 0; w < W; w++) begin
      for (int c = 0; c < C; c++) begin
        re = (w == W - 1) && (c == C - 1);
        e  = {in_row_last_i & re, re, in_row_i[w][c]};
        exp_q.push_back(e);
      end
    end
    rem = RB;
  endtask

  // One clock: compare at mid-low phase, then advance the model on the posedge.
  task automatic step(output bit xfer);
    logic          exp_acc;
    bit            beat;
    logic [VB+1:0] e;
    #1;
    exp_acc = !reset_i && (rem == 0 || (rem == 1 && out_ready_i));
    check("accept", in_row_accept_o, exp_acc);
    check("valid", out_valid_o, rem > 0);
    check("frames", frames_done_o, frames_exp);
    if (rem > 0) begin
      e = exp_q[0];
      check("value", out_value_o, e[VB-1:0]);
      check("row_end", out_row_end_o, e[VB]);
      check("last", out_last_o, e[VB+1]);
    end
    beat = (rem > 0) && out_ready_i;
    xfer = in_row_valid_i && exp_acc;
    @(posedge clock_i);
    cyc++;
    if (reset_i) begin
      rem = 0;
      exp_q.delete();
      frames_exp = '0;
    end else begin
      if (beat) begin
        e = exp_q.pop_front();
        rem--;
        if (e[VB+1]) frames_exp++;
        beat_count++;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
      end
      if (xfer) push_row();
    end
    @(negedge clock_i);
  endtask

  task automatic fill_pattern(input int r);
    for (int w = 0; w < W; w++)
      for (int c = 0; c < C; c++)
        in_row_i[w][c] = VB'(w + c + 56 * r);
  endtask

  task automatic fill_random();
    for (int w = 0; w < W; w++)
      for (int c = 0; c < C; c++)
        in_row_i[w][c] = VB'($urandom_range(0, 255));
  endtask

  task automatic drain(input int limit);
    bit x;
    int n = 0;
    while (rem > 0 && n < limit) begin
      step(x);
      n++;
    end
    if (rem > 0) check("drain_timeout", 32'(rem), 0);
  endtask

  initial begin
    bit            x;
    int            b0;
    int            n;
    logic [VB-1:0] b00;

    reset_i = 1'b1;
    in_row_valid_i = 1'b1;
    in_row_last_i = 1'b0;
    out_ready_i = 1'b1;
    fill_random();
    @(negedge clock_i);

    // Reset held with a row offered: nothing is accepted.
    repeat (5) step(x);
    reset_i = 1'b0;
    in_row_valid_i = 1'b0;
    step(x);

    // Single row, value = col + ch.
    b0 = beat_count;
    fill_pattern(0);
    in_row_valid_i = 1'b1;
    step(x);
    in_row_valid_i = 1'b0;
    drain(200);
    check("single_beats", 32'(beat_count - b0), RB);

    // 28-row frame, writer holds valid until accepted, ready always high.
    b0 = beat_count;
    first_beat_cyc = -1;
    for (int r = 0; r < 28; r++) begin
      fill_pattern(r);
      in_row_last_i = (r == 27);
      in_row_valid_i = 1'b1;
      n = 0;
      do begin
        step(x);
        n++;
      end while (!x && n < 200);
      if (!x) check("frame_accept_timeout", 0, 1);
    end
    in_row_valid_i = 1'b0;
    in_row_last_i = 1'b0;
    drain(200);
    check("frame_beats", 32'(beat_count - b0), 28 * RB);
    check("frame_no_bubble", 32'(last_beat_cyc - first_beat_cyc + 1), 28 * RB);
    check("frames_after_frame", frames_done_o, 1);

    // Backpressure: ready alternates while one row drains.
    b0 = beat_count;
    fill_random();
    in_row_valid_i = 1'b1;
    step(x);
    in_row_valid_i = 1'b0;
    n = 0;
    while (rem > 0 && n < 400) begin
      out_ready_i = n[0];
      step(x);
      n++;
    end
    out_ready_i = 1'b1;
    if (rem > 0) check("bp_timeout", 32'(rem), 0);
    check("bp_beats", 32'(beat_count - b0), RB);

    // Reset after 10 beats discards the row and clears the frame count.
    fill_random();
    in_row_valid_i = 1'b1;
    step(x);
    in_row_valid_i = 1'b0;
    repeat (10) step(x);
    reset_i = 1'b1;
    step(x);
    reset_i = 1'b0;
    step(x);
    fill_random();
    in_row_last_i = 1'b1;
    in_row_valid_i = 1'b1;
    step(x);
    in_row_valid_i = 1'b0;
    in_row_last_i = 1'b0;
    drain(200);
    check("frames_after_reset", frames_done_o, 1);

    // Row B offered during row A's final beat is taken with no gap.
    fill_random();
    in_row_valid_i = 1'b1;
    step(x);
    in_row_valid_i = 1'b0;
    while (rem > 1) step(x);
    fill_random();
    b00 = in_row_i[0][0];
    in_row_valid_i = 1'b1;
    #1;
    check("simul_accept", in_row_accept_o, 1);
    step(x);
    in_row_valid_i = 1'b0;
    #1;
    check("simul_b00", out_value_o, b00);
    drain(200);

    // Random traffic on both sides.
    for (int k = 0; k < 600; k++) begin
      fill_random();
      in_row_valid_i = ($urandom_range(0, 3) != 0);
      in_row_last_i = ($urandom_range(0, 2) == 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      step(x);
    end
    in_row_valid_i = 1'b0;
    out_ready_i = 1'b1;
    drain(200);
    step(x);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
